// File: rtl/fifo_drain_serializer.sv
// FIFO read-side drain: pops words and shifts them out MSB-first,
// holding each bit for DIV clocks with frame/last qualifiers.
module fifo_drain_serializer #(
  parameter int DATA_W = 32,
  parameter int DIV    = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int BW = $clog2(DATA_W);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LATCH,
    SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DW-1:0]     div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic div_end;
  logic bit_zero;
  logic pending;

  assign div_end  = (div_q == DW'(DIV - 1));
  assign bit_zero = (bit_q == '0);
  assign pending  = enable && !fifo_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pending) state_d = READ;
      end
      READ: begin
        state_d = LATCH;
      end
      LATCH: begin
        shift_d = fifo_data;
        bit_d   = BW'(DATA_W - 1);
        div_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_end) begin
          shift_d = shift_q << 1;
          div_d   = '0;
          bit_d   = bit_q - 1'b1;
          // final hold cycle of bit 0 closes the frame
          if (bit_zero) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = pending ? READ : IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase
  end

  assign fifo_rd    = (state_q == READ);
  assign ser_valid  = (state_q == SHIFT);
  assign ser_out    = ser_valid && shift_q[DATA_W-1];
  assign ser_last   = ser_valid && bit_zero;
  assign busy       = (state_q != IDLE);
  assign word_count = cnt_q;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench: two serializers (DIV=4/CNT_W=16 and DIV=1/CNT_W=2) fed by
// behavioural FIFOs; frames are rebuilt and scored against pushed words.
module tb_fifo_drain_serializer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, rst_b;
  logic [1:0]  en, fe, rd, so, sv, sl, bz;
  logic [31:0] fdata [2];
  logic [15:0] wc_a;
  logic [1:0]  wc_b;

  fifo_drain_serializer #(.DATA_W(32), .DIV(4), .CNT_W(16)) dut_a (
    .clock(clock), .reset(rst_a), .enable(en[0]),
    .fifo_empty(fe[0]), .fifo_data(fdata[0]),
    .fifo_rd(rd[0]), .ser_out(so[0]), .ser_valid(sv[0]),
    .ser_last(sl[0]), .busy(bz[0]), .word_count(wc_a)
  );

  fifo_drain_serializer #(.DATA_W(32), .DIV(1), .CNT_W(2)) dut_b (
    .clock(clock), .reset(rst_b), .enable(en[1]),
    .fifo_empty(fe[1]), .fifo_data(fdata[1]),
    .fifo_rd(rd[1]), .ser_out(so[1]), .ser_valid(sv[1]),
    .ser_last(sl[1]), .busy(bz[1]), .word_count(wc_b)
  );

  // behavioural FIFOs with registered read data
  logic [31:0] fmem [2][64];
  int wp [2];
  int rp [2];
  assign fe[0] = (rp[0] == wp[0]);
  assign fe[1] = (rp[1] == wp[1]);

  initial begin
    wp[0] = 0; wp[1] = 0;
    rp[0] = 0; rp[1] = 0;
    fdata[0] = '0; fdata[1] = '0;
  end

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (rd[i] && rp[i] < wp[i]) begin
        fdata[i] <= fmem[i][rp[i]];
        rp[i]    <= rp[i] + 1;
      end
    end
  end

  // monitor state
  int          cyc = 0;
  int          mcnt [2];
  logic        mbad [2];
  logic [31:0] mw [2];
  logic        pend [2];
  logic        prd [2];
  int          rdn [2];
  int          svn [2];
  int          sln [2];
  int          glitch [2];
  logic [31:0] rxq [2][$];
  logic        badq [2][$];
  int          rdq [2][$];
  int          firstq [2][$];
  int          wcq [2][$];
  logic [31:0] expq [2][$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; mbad[i] = 0; mw[i] = '0; pend[i] = 0;
      prd[i] = 0; rdn[i] = 0; svn[i] = 0; sln[i] = 0;
      glitch[i] = 0;
    end
  end

  always @(negedge clock) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      int dv;
      int wcv;
      logic rs;
      dv  = (i == 0) ? 4 : 1;
      wcv = (i == 0) ? int'(wc_a) : int'(wc_b);
      rs  = (i == 0) ? rst_a : rst_b;
      if (rs) begin
        mcnt[i] = 0; mbad[i] = 0; pend[i] = 0; prd[i] = 0;
      end else begin
        if (pend[i]) begin
          wcq[i].push_back(wcv);
          pend[i] = 0;
        end
        if (rd[i]) begin
          rdq[i].push_back(cyc);
          rdn[i]++;
          if (prd[i]) glitch[i]++;
        end
        prd[i] = rd[i];
        if (!sv[i] && (so[i] || sl[i])) glitch[i]++;
        if (sv[i]) begin
          svn[i]++;
          if (sl[i]) sln[i]++;
          if (mcnt[i] == 0) firstq[i].push_back(cyc);
          if (mcnt[i] % dv == 0) mw[i] = {mw[i][30:0], so[i]};
          else if (so[i] != mw[i][0]) mbad[i] = 1;
          if (sl[i] != (mcnt[i] >= 31 * dv)) mbad[i] = 1;
          mcnt[i]++;
          if (mcnt[i] == 32 * dv) begin
            rxq[i].push_back(mw[i]);
            badq[i].push_back(mbad[i]);
            pend[i] = 1;
            mcnt[i] = 0;
            mbad[i] = 0;
          end
        end else if (mcnt[i] != 0) begin
          glitch[i]++;
          mcnt[i] = 0;
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [31:0] w, input bit ex);
    fmem[i][wp[i]] = w;
    wp[i] = wp[i] + 1;
    if (ex) expq[i].push_back(w);
  endtask

  task automatic wait_rx(input int i, input int n, input int budget);
    int k;
    k = 0;
    while (rxq[i].size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("rx_timeout", 64'(rxq[i].size() >= n), 64'd1);
  endtask

  task automatic wait_sv(input int i, input int budget);
    int k;
    k = 0;
    while (!sv[i] && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("sv_timeout", 64'(sv[i]), 64'd1);
  endtask

  task automatic score(input int i, input string tag);
    logic [31:0] got;
    logic [31:0] exp;
    logic        bad;
    if (rxq[i].size() == 0 || expq[i].size() == 0) begin
      chk({tag, "_missing"}, 64'd0, 64'd1);
    end else begin
      got = rxq[i].pop_front();
      bad = badq[i].pop_front();
      exp = expq[i].pop_front();
      chk(tag, 64'(got), 64'(exp));
      chk({tag, "_shape"}, 64'(bad), 64'd0);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    en    = 2'b00;
    repeat (3) @(negedge clock);
    chk("rst_a_outs", 64'({rd[0], so[0], sv[0], sl[0], bz[0]}), 64'd0);
    chk("rst_a_wc", 64'(wc_a), 64'd0);
    chk("rst_b_outs", 64'({rd[1], so[1], sv[1], sl[1], bz[1]}), 64'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // empty FIFO with enable held high
    en[0] = 1'b1;
    repeat (100) @(negedge clock);
    chk("empty_rd", 64'(rdn[0]), 64'd0);
    chk("empty_busy", 64'(bz[0]), 64'd0);
    chk("empty_wc", 64'(wc_a), 64'd0);

    // single word, DIV=4
    push(0, 32'hA5A5_0F0F, 1);
    wait_rx(0, 1, 400);
    score(0, "w_a5a5");
    repeat (3) @(negedge clock);
    chk("a_rd_pulses", 64'(rdn[0]), 64'd1);
    if (rdq[0].size() > 0 && firstq[0].size() > 0)
      chk("a_latency", 64'(firstq[0][0] - rdq[0][0]), 64'd2);
    else
      chk("a_latency_missing", 64'd0, 64'd1);
    chk("a_sv_cycles", 64'(svn[0]), 64'd128);
    chk("a_last_cycles", 64'(sln[0]), 64'd4);
    chk("a_wc1", 64'(wc_a), 64'd1);
    chk("a_idle", 64'(bz[0]), 64'd0);

    // three words back-to-back, DIV=1
    push(1, 32'h0000_0001, 1);
    push(1, 32'h8000_0000, 1);
    push(1, 32'hFFFF_FFFF, 1);
    en[1] = 1'b1;
    wait_rx(1, 3, 300);
    score(1, "b_w0");
    score(1, "b_w1");
    score(1, "b_w2");
    repeat (5) @(negedge clock);
    chk("b_rd_pulses", 64'(rdn[1]), 64'd3);
    if (rdq[1].size() >= 3) begin
      chk("b_gap01", 64'(rdq[1][1] - rdq[1][0]), 64'd34);
      chk("b_gap12", 64'(rdq[1][2] - rdq[1][1]), 64'd34);
    end else begin
      chk("b_gap_missing", 64'd0, 64'd1);
    end
    chk("b_sv_cycles", 64'(svn[1]), 64'd96);
    chk("b_last_cycles", 64'(sln[1]), 64'd3);
    chk("b_busy", 64'(bz[1]), 64'd0);
    chk("b_wc3", 64'(wc_b), 64'd3);

    // enable dropped mid-frame
    push(0, 32'h1234_5678, 1);
    push(0, 32'h9ABC_DEF0, 0);
    wait_sv(0, 20);
    repeat (40) @(negedge clock);
    en[0] = 1'b0;
    wait_rx(0, 1, 300);
    score(0, "w_drop");
    repeat (20) @(negedge clock);
    chk("drop_rd", 64'(rdn[0]), 64'd2);
    chk("drop_fifo", 64'(wp[0] - rp[0]), 64'd1);
    chk("drop_idle", 64'(bz[0]), 64'd0);
    chk("drop_wc", 64'(wc_a), 64'd2);

    // asynchronous reset mid-frame; the held word is lost
    en[0] = 1'b1;
    wait_sv(0, 20);
    repeat (80) @(negedge clock);
    #2 rst_a = 1'b1;
    #1;
    chk("arst_outs", 64'({rd[0], so[0], sv[0], sl[0], bz[0]}), 64'd0);
    chk("arst_wc", 64'(wc_a), 64'd0);
    push(0, 32'hC0FF_EE11, 1);
    @(negedge clock);
    @(negedge clock);
    rst_a = 1'b0;
    wait_rx(0, 1, 300);
    score(0, "w_after_rst");
    repeat (3) @(negedge clock);
    chk("arst_wc1", 64'(wc_a), 64'd1);

    // counter wrap on the 2-bit instance
    push(1, 32'h0F0F_F0F0, 1);
    push(1, 32'h7FFF_FFFE, 1);
    wait_rx(1, 2, 200);
    score(1, "b_w3");
    score(1, "b_w4");
    repeat (5) @(negedge clock);
    if (wcq[1].size() == 5) begin
      chk("wrap_0", 64'(wcq[1][0]), 64'd1);
      chk("wrap_1", 64'(wcq[1][1]), 64'd2);
      chk("wrap_2", 64'(wcq[1][2]), 64'd3);
      chk("wrap_3", 64'(wcq[1][3]), 64'd0);
      chk("wrap_4", 64'(wcq[1][4]), 64'd1);
    end else begin
      chk("wrap_len", 64'(wcq[1].size()), 64'd5);
    end

    chk("a_glitch", 64'(glitch[0]), 64'd0);
    chk("b_glitch", 64'(glitch[1]), 64'd0);
    chk("a_leftover", 64'(expq[0].size()), 64'd0);
    chk("b_leftover", 64'(expq[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
- Read-side consumer for the team's synchronous FIFO. It pops 32-bit words through the FIFO's rn/empty/registered-data interface and shifts each word out MSB-first on a single-bit serial line.
- Each bit is held for a programmable number of clocks, and the line carries frame and last-bit qualifiers.
- Sits between the FIFO output and a downstream serial sink, such as a test probe or link driver.

Parameters:
- DATA_W, 32, width of FIFO word and serial frame length in bits (>=2).
- DIV, 4, clock cycles each bit is held on ser_out (>=1).
- CNT_W, 16, width of the completed-word counter.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits starting a new word; sampled only at word boundaries.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_W  FIFO registered read data; valid the cycle after a pop.
- fifo_rd  output  1  pop request to FIFO (drives FIFO rn); one-cycle pulse.
- ser_out  output  1  serial data, MSB first.
- ser_valid  output  1  high for every cycle a frame bit is on ser_out.
- ser_last  output  1  high during all DIV cycles of bit 0 (the final bit).
- busy  output  1  high whenever state != IDLE.
- word_count  output  CNT_W  number of fully transmitted words.

Behaviour:
- Reset (async, immediate, also mid-frame):
  - state=IDLE.
  - fifo_rd=0, ser_out=0, ser_valid=0, ser_last=0, busy=0, word_count=0.
  - Shift register, bit counter and divider counter cleared.
  - An aborted word is lost; it is not re-popped.
- FSM states: IDLE, READ, LATCH, SHIFT.
- IDLE:
  - If enable=1 and fifo_empty=0, go to READ.
  - Otherwise stay.
- READ:
  - fifo_rd=1 for exactly this cycle.
  - Always go to LATCH.
- LATCH:
  - FIFO data is now valid.
  - At the end of the cycle: shift_reg<=fifo_data, bit_cnt<=DATA_W-1, div_cnt<=0.
  - Go to SHIFT.
- SHIFT:
  - ser_valid=1 and ser_out=shift_reg[DATA_W-1]. Both are valid in the same cycle.
  - div_cnt counts 0..DIV-1. At DIV-1, shift the register left by 1, decrement bit_cnt and reset div_cnt.
  - ser_last=1 while bit_cnt==0.
  - On the last cycle of bit 0, word_count increments (wraps modulo 2^CNT_W), then:
    - If enable=1 and fifo_empty=0, go to READ (back-to-back words, 2-cycle gap).
    - Otherwise go to IDLE.
- Timing:
  - Latency: IDLE with a pending word → READ next cycle → LATCH → first bit on the 3rd cycle after the IDLE decision.
  - A frame occupies exactly DATA_W*DIV cycles of ser_valid=1.
  - Minimum per-word period is DATA_W*DIV+2 cycles.
- Boundaries and simultaneous events:
  - enable deasserted mid-frame: the current frame completes; no new pop follows.
  - fifo_empty is ignored outside IDLE and the final SHIFT cycle. The block never pops when empty, so there is no underflow.
  - fifo_rd is never asserted in two consecutive cycles.
  - DIV=1: one bit per clock, and ser_last is high for one cycle.
  - With ser_valid=0, ser_out is 0.

Test Plan:
- Reset, then enable=1 with FIFO holding 0xA5A5_0F0F (DIV=4) → fifo_rd is a single pulse; ser_valid is high for 128 cycles starting 3 cycles after the pop decision; bits sample as 1010_0101...1111 MSB-first; ser_last high for the final 4 cycles; word_count=1.
- FIFO holds 3 words 0x0000_0001, 0x8000_0000, 0xFFFF_FFFF, enable=1, DIV=1 → exactly 3 fifo_rd pulses spaced 34 cycles apart; each frame is 32 bits; word_count=3; busy drops after the third frame.
- FIFO empty, enable=1 for 100 cycles → fifo_rd never asserts, busy=0, word_count=0.
- enable dropped at bit 10 of the first of 2 queued words → word 1 finishes intact; no second pop; the FIFO still holds 1 word; state is IDLE.
- reset asserted asynchronously (between edges) at bit 20 → all outputs go to 0 immediately and word_count=0. After release with FIFO non-empty, the next word is popped and sent from its MSB.
- CNT_W=2 with 5 words sent → word_count sequence 1,2,3,0,1 (wraps).
